// File: rtl/conversor_bcd_binario_if.sv
// conversor_bcd_binario_if: request digits and converted-result signals of the BCD-to-binary converter
interface conversor_bcd_binario_if;
   logic       inicio;
   logic [3:0] dez;
   logic [3:0] uni;
   logic [6:0] bin;
   logic       cabe4;
   logic       erro;
   logic       ocupado;
   logic       pronto;
   modport master (output inicio, dez, uni, input bin, cabe4, erro, ocupado, pronto);
   modport slave  (input inicio, dez, uni, output bin, cabe4, erro, ocupado, pronto);
endinterface

// File: rtl/conversor_bcd_binario.sv
// conversor_bcd_binario: two BCD digits to 7-bit binary by iterative reverse double-dabble
module conversor_bcd_binario (
   input logic             clk,
   input logic             rst_n,
   conversor_bcd_binario_if.slave io
);
   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
   state_t      state, nxt;
   logic [14:0] work, work_n, shf, cor;
   logic [2:0]  cnt, cnt_n;
   logic [6:0]  bin_n;
   logic        cabe4_n, erro_n, ocupado_n, pronto_n;
   // the work register itself holds the latched digits, so later input changes cannot disturb a conversion
   always_comb begin
      shf = work >> 1;
      cor = {shf[14:11] >= 4'd8 ? shf[14:11] - 4'd3 : shf[14:11],
             shf[10:7]  >= 4'd8 ? shf[10:7]  - 4'd3 : shf[10:7], shf[6:0]};
   end
   always_comb begin
      nxt      = state;
      work_n   = work;
      cnt_n    = cnt;
      bin_n    = io.bin;
      cabe4_n  = io.cabe4;
      erro_n   = io.erro;
      pronto_n = 1'b0;
      case (state)
         CONV: begin
            work_n = cor;
            cnt_n  = cnt + 3'd1;
            if (cnt == 3'd6) begin
               nxt      = DONE;
               bin_n    = cor[6:0];
               cabe4_n  = cor[6:0] <= 7'd15;
               erro_n   = 1'b0;
               pronto_n = 1'b1;
            end
         end
         default: begin
            if (io.inicio && (io.dez > 4'd9 || io.uni > 4'd9)) begin
               nxt      = DONE;
               bin_n    = 7'd0;
               cabe4_n  = 1'b0;
               erro_n   = 1'b1;
               pronto_n = 1'b1;
            end else if (io.inicio) begin
               nxt    = CONV;
               work_n = {io.dez, io.uni, 7'd0};
               cnt_n  = 3'd0;
            end else begin
               nxt = IDLE;
            end
         end
      endcase
      ocupado_n = nxt == CONV;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         work       <= 15'd0;
         cnt        <= 3'd0;
         io.bin     <= 7'd0;
         io.cabe4   <= 1'b1;
         io.erro    <= 1'b0;
         io.ocupado <= 1'b0;
         io.pronto  <= 1'b0;
      end else begin
         state      <= nxt;
         work       <= work_n;
         cnt        <= cnt_n;
         io.bin     <= bin_n;
         io.cabe4   <= cabe4_n;
         io.erro    <= erro_n;
         io.ocupado <= ocupado_n;
         io.pronto  <= pronto_n;
      end
   end
endmodule
